// File: rtl/osc_pkg.sv
// Shared types and defaults for the emulated-oscillator controller.
package osc_pkg;

    localparam int DT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } osc_state_t;

endpackage

// File: rtl/osc_model_ctrl.sv
// Emulated clock oscillator: tracks time to its next edge and advances
// by the globally committed timestep each emulator cycle.
module osc_model_ctrl
    import osc_pkg::*;
#(
    parameter int DT_WIDTH  = DT_WIDTH_DEF,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic [DT_WIDTH-1:0]  t_lo,
    input  logic [DT_WIDTH-1:0]  t_hi,
    input  logic [DT_WIDTH-1:0]  emu_dt,
    output logic [DT_WIDTH-1:0]  dt_req,
    output logic                 clk_val,
    output logic                 clk_posedge,
    output logic                 clk_negedge,
    output logic [CNT_WIDTH-1:0] edge_cnt,
    output logic                 err_overshoot
);

    osc_state_t          state;
    logic [DT_WIDTH-1:0] t_rem;
    logic [DT_WIDTH-1:0] t_lo_eff;
    logic [DT_WIDTH-1:0] t_hi_eff;
    logic                adv;
    logic                hit;
    logic                over;

    // Zero-length phases would stall the time manager's min-reduction.
    assign t_lo_eff = (t_lo == '0) ? DT_WIDTH'(1) : t_lo;
    assign t_hi_eff = (t_hi == '0) ? DT_WIDTH'(1) : t_hi;

    assign adv  = (emu_dt != '0);
    assign hit  = adv && (emu_dt >= t_rem);
    assign over = emu_dt > t_rem;

    assign dt_req = (!emu_rst_n || state == INIT) ? '1 : t_rem;

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state         <= INIT;
            t_rem         <= '0;
            clk_val       <= 1'b0;
            clk_posedge   <= 1'b0;
            clk_negedge   <= 1'b0;
            edge_cnt      <= '0;
            err_overshoot <= 1'b0;
        end else begin
            clk_posedge <= 1'b0;
            clk_negedge <= 1'b0;
            case (state)
                INIT: begin
                    t_rem   <= t_lo_eff;
                    clk_val <= 1'b0;
                    state   <= LO;
                end
                LO: begin
                    if (hit) begin
                        if (over) err_overshoot <= 1'b1;
                        state       <= HI;
                        t_rem       <= t_hi_eff;
                        clk_val     <= 1'b1;
                        clk_posedge <= 1'b1;
                        edge_cnt    <= edge_cnt + CNT_WIDTH'(1);
                    end else begin
                        t_rem <= t_rem - emu_dt;
                    end
                end
                HI: begin
                    if (hit) begin
                        if (over) err_overshoot <= 1'b1;
                        state       <= LO;
                        t_rem       <= t_lo_eff;
                        clk_val     <= 1'b0;
                        clk_negedge <= 1'b1;
                    end else begin
                        t_rem <= t_rem - emu_dt;
                    end
                end
                default: begin
                    state   <= INIT;
                    clk_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_model_ctrl.sv
// Self-checking bench for osc_model_ctrl: vector table, corner sequences,
// and random stimulus against a phase/time reference model.
module tb_osc_model_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          emu_clk;
    logic          emu_rst_n;
    logic [DW-1:0] t_lo;
    logic [DW-1:0] t_hi;
    logic [DW-1:0] emu_dt;
    logic [DW-1:0] dt_req;
    logic          clk_val;
    logic          clk_posedge;
    logic          clk_negedge;
    logic [CW-1:0] edge_cnt;
    logic          err_overshoot;

    osc_model_ctrl #(.DT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .emu_clk       (emu_clk),
        .emu_rst_n     (emu_rst_n),
        .t_lo          (t_lo),
        .t_hi          (t_hi),
        .emu_dt        (emu_dt),
        .dt_req        (dt_req),
        .clk_val       (clk_val),
        .clk_posedge   (clk_posedge),
        .clk_negedge   (clk_negedge),
        .edge_cnt      (edge_cnt),
        .err_overshoot (err_overshoot)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: which phase we are in and how much time is left.
    // m_phase: 0 = waiting for first cycle after reset, 1 = low, 2 = high.
    int      m_phase;
    longint  m_left;
    int      m_rises;
    bit      m_err;
    bit      m_rise_pulse;
    bit      m_fall_pulse;
    logic [DW-1:0] pre_req;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic longint dur(input logic [DW-1:0] d);
        return (d == 0) ? 1 : longint'(d);
    endfunction

    function automatic logic [63:0] m_req();
        if (m_phase == 0) return 64'(32'hFFFF_FFFF);
        return 64'(m_left);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_left = 0;
        m_rises = 0;
        m_err = 0;
        m_rise_pulse = 0;
        m_fall_pulse = 0;
    endtask

    task automatic model_cycle(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                               input logic [DW-1:0] dt);
        longint step_t;
        step_t = longint'(dt);
        m_rise_pulse = 0;
        m_fall_pulse = 0;
        if (m_phase == 0) begin
            m_phase = 1;
            m_left = dur(lo);
        end else if (step_t < m_left) begin
            m_left = m_left - step_t;
        end else begin
            if (step_t > m_left) m_err = 1;
            if (m_phase == 1) begin
                m_phase = 2;
                m_left = dur(hi);
                m_rise_pulse = 1;
                m_rises = m_rises + 1;
            end else begin
                m_phase = 1;
                m_left = dur(lo);
                m_fall_pulse = 1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".dt_req"}, 64'(dt_req), m_req());
        chk({tag, ".clk_val"}, 64'(clk_val), 64'(m_phase == 2));
        chk({tag, ".posedge"}, 64'(clk_posedge), 64'(m_rise_pulse));
        chk({tag, ".negedge"}, 64'(clk_negedge), 64'(m_fall_pulse));
        chk({tag, ".edge_cnt"}, 64'(edge_cnt), 64'(m_rises % (1 << CW)));
        chk({tag, ".err"}, 64'(err_overshoot), 64'(m_err));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                        input logic [DW-1:0] dt, input string tag);
        t_lo = lo;
        t_hi = hi;
        emu_dt = dt;
        #1;
        pre_req = dt_req;
        chk({tag, ".dt_req_pre"}, 64'(dt_req), m_req());
        @(posedge emu_clk);
        model_cycle(lo, hi, dt);
        @(negedge emu_clk);
        check_outs(tag);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".rst_dt_req"}, 64'(dt_req), 64'(32'hFFFF_FFFF));
        chk({tag, ".rst_val"}, 64'(clk_val), 64'd0);
        chk({tag, ".rst_pos"}, 64'(clk_posedge), 64'd0);
        chk({tag, ".rst_neg"}, 64'(clk_negedge), 64'd0);
        chk({tag, ".rst_cnt"}, 64'(edge_cnt), 64'd0);
        chk({tag, ".rst_err"}, 64'(err_overshoot), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        emu_rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outs(tag);
        @(posedge emu_clk);
        @(negedge emu_clk);
        check_reset_outs(tag);
        emu_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic [DW-1:0] dt;
        logic [DW-1:0] exp_req;
        logic          exp_val;
        logic          exp_pos;
        logic          exp_neg;
    } vec_t;

    vec_t vt[7];

    initial begin
        emu_rst_n = 1'b0;
        t_lo = '0;
        t_hi = '0;
        emu_dt = '0;
        model_reset();

        vt[0] = '{32'd10, 32'd2, 32'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'd10, 32'd2, 32'd4,  32'd10,        1'b0, 1'b0, 1'b0};
        vt[2] = '{32'd10, 32'd2, 32'd4,  32'd6,         1'b0, 1'b0, 1'b0};
        vt[3] = '{32'd10, 32'd2, 32'd2,  32'd2,         1'b1, 1'b1, 1'b0};
        vt[4] = '{32'd10, 32'd2, 32'd1,  32'd2,         1'b1, 1'b0, 1'b0};
        vt[5] = '{32'd10, 32'd2, 32'd1,  32'd1,         1'b0, 1'b0, 1'b1};
        vt[6] = '{32'd10, 32'd2, 32'd10, 32'd10,        1'b1, 1'b1, 1'b0};

        @(negedge emu_clk);
        @(negedge emu_clk);
        check_reset_outs("por");
        emu_rst_n = 1'b1;

        // Partial steps via vector table.
        for (int i = 0; i < 7; i++) begin
            step(vt[i].lo, vt[i].hi, vt[i].dt, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_req", i), 64'(pre_req), 64'(vt[i].exp_req));
            chk($sformatf("vec%0d.tbl_val", i), 64'(clk_val), 64'(vt[i].exp_val));
            chk($sformatf("vec%0d.tbl_pos", i), 64'(clk_posedge), 64'(vt[i].exp_pos));
            chk($sformatf("vec%0d.tbl_neg", i), 64'(clk_negedge), 64'(vt[i].exp_neg));
        end

        // Basic toggling: 3 low, 5 high, period 8 cycles after INIT.
        do_reset("tog_rst");
        for (int i = 0; i < 24; i++) begin
            step(32'd3, 32'd5, 32'd1, $sformatf("tog%0d", i));
            chk($sformatf("tog%0d.pat_val", i), 64'(clk_val), 64'((i % 8) >= 3));
            chk($sformatf("tog%0d.pat_pos", i), 64'(clk_posedge), 64'((i % 8) == 3));
            chk($sformatf("tog%0d.pat_neg", i), 64'(clk_negedge),
                64'((i % 8) == 0 && i >= 8));
        end

        // Overshoot is sticky until reset.
        do_reset("ovs_rst");
        step(32'd4, 32'd3, 32'd0, "ovs_init");
        step(32'd4, 32'd3, 32'd7, "ovs_hit");
        chk("ovs.val", 64'(clk_val), 64'd1);
        chk("ovs.err", 64'(err_overshoot), 64'd1);
        chk("ovs.req_hi", 64'(dt_req), 64'd3);
        for (int i = 0; i < 10; i++) step(32'd4, 32'd3, 32'd1, "ovs_run");
        chk("ovs.sticky", 64'(err_overshoot), 64'd1);

        // Zero durations and zero timestep.
        do_reset("zero_rst");
        step(32'd0, 32'd0, 32'd5, "zero_init");
        chk("zero.lo_req", 64'(dt_req), 64'd1);
        step(32'd0, 32'd0, 32'd1, "zero_rise");
        chk("zero.hi_req", 64'(dt_req), 64'd1);
        for (int i = 0; i < 20; i++) step(32'd9, 32'd9, 32'd0, "zero_dt");
        chk("zero.hold_val", 64'(clk_val), 64'd1);
        chk("zero.hold_req", 64'(dt_req), 64'd1);
        chk("zero.err", 64'(err_overshoot), 64'd0);

        // Async reset for half a cycle in the middle of a high phase.
        do_reset("ar_rst");
        step(32'd2, 32'd6, 32'd1, "ar_a");
        step(32'd2, 32'd6, 32'd1, "ar_b");
        step(32'd2, 32'd6, 32'd9, "ar_c");
        step(32'd2, 32'd6, 32'd1, "ar_d");
        chk("ar.in_hi", 64'(clk_val), 64'd1);
        emu_rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outs("ar_mid");
        @(posedge emu_clk);
        #1;
        check_reset_outs("ar_edge");
        emu_rst_n = 1'b1;
        @(negedge emu_clk);
        for (int i = 0; i < 6; i++) step(32'd2, 32'd6, 32'd1, "ar_restart");
        chk("ar.first_edge", 64'(edge_cnt), 64'd1);

        // Counter wrap at 4 bits: 17 rising edges.
        do_reset("wrap_rst");
        for (int i = 0; i < 35; i++) step(32'd1, 32'd1, 32'd1, "wrap");
        chk("wrap.cnt", 64'(edge_cnt), 64'd1);

        // Random stimulus, including mid-phase duration changes.
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] lo, hi, dt;
            lo = DW'($urandom_range(0, 7));
            hi = DW'($urandom_range(0, 7));
            dt = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(8, 20))
                                             : DW'($urandom_range(0, 4));
            step(lo, hi, dt, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osc_model_ctrl.md
OSC_MODEL_CTRL -- requirements
Module: osc_model_ctrl

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 32: width of all time quantities, in DT_SCALE units.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the edge counter.
REQ-003 SHALL have port emu_clk, input, 1: the single emulator clock; all state updates on its rising edge.
REQ-004 SHALL have port emu_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port t_lo, input, DT_WIDTH: low-phase duration of the emulated clock.
REQ-006 SHALL have port t_hi, input, DT_WIDTH: high-phase duration of the emulated clock.
REQ-007 SHALL have port emu_dt, input, DT_WIDTH: global timestep committed by the time manager this cycle.
REQ-008 SHALL have port dt_req, output, DT_WIDTH: time remaining to this oscillator's next edge, fed to the time manager.
REQ-009 SHALL have port clk_val, output, 1: current level of the emulated clock.
REQ-010 SHALL have port clk_posedge, output, 1: one-cycle pulse on each emulated rising edge.
REQ-011 SHALL have port clk_negedge, output, 1: one-cycle pulse on each emulated falling edge.
REQ-012 SHALL have port edge_cnt, output, CNT_WIDTH: number of emulated rising edges since reset.
REQ-013 SHALL have port err_overshoot, output, 1: sticky flag, set when emu_dt exceeded dt_req.

Function
REQ-014 SHALL implement FSM states INIT, LO, HI; current phase duration is held in register t_rem.
REQ-015 SHALL, in INIT, drive dt_req all-ones (no constraint), ignore emu_dt, load t_rem = max(t_lo,1), and go to LO next cycle.
REQ-016 SHALL, in LO/HI, drive dt_req = t_rem combinationally (zero-latency path to the time manager).
REQ-017 SHALL, in LO/HI with emu_dt < t_rem, set t_rem <= t_rem - emu_dt and keep the state.
REQ-018 SHALL, in LO with emu_dt >= t_rem, go to HI, load t_rem = max(t_hi,1), pulse clk_posedge next cycle, and increment edge_cnt.
REQ-019 SHALL, in HI with emu_dt >= t_rem, go to LO, load t_rem = max(t_lo,1), and pulse clk_negedge next cycle.
REQ-020 SHALL treat emu_dt == 0 as no time advance, with no change to t_rem or state.
REQ-021 SHALL, when emu_dt > t_rem in LO/HI, set err_overshoot and still take the edge; the excess time is discarded, not carried over.
REQ-022 SHALL sample t_lo/t_hi only at phase load; changes mid-phase take effect from the next phase.
REQ-023 SHALL treat a zero duration as 1 unit, so dt_req is never 0 in LO/HI.
REQ-024 SHALL drive clk_val = 1 in HI only, as a registered output.
REQ-025 SHALL wrap edge_cnt modulo 2^CNT_WIDTH with no flag.
REQ-026 SHALL use unsigned arithmetic throughout; the subtraction never underflows because of the >= test.

Reset
REQ-027 SHALL, on emu_rst_n low and independent of emu_clk, force state=INIT, t_rem=0, clk_val=0, clk_posedge=0, clk_negedge=0, edge_cnt=0, err_overshoot=0.
REQ-028 SHALL, while in reset, drive dt_req all-ones.
REQ-029 SHALL, on reset mid-phase, abandon the phase immediately; the first edge after release comes t_lo after INIT.
REQ-030 SHALL clear err_overshoot only by reset.

Structure
REQ-031 SHALL place the state enum (INIT/LO/HI) and the default DT_WIDTH constant in shared package osc_pkg.
REQ-032 SHALL be a single flat module with no sub-modules; one instance per oscillator feeds the time manager's min-reduction.

Verification
REQ-033 SHALL cover basic toggling: t_lo=3, t_hi=5, emu_dt=1 each cycle -> after INIT, clk_val=0 for 3 cycles, then 1 for 5 cycles, repeating; a clk_posedge pulse at each 0->1 transition.
REQ-034 SHALL cover partial steps: t_lo=10, emu_dt sequence 4,4,2 -> dt_req reads 10, 6, 2, then HI is entered.
REQ-035 SHALL cover overshoot: t_lo=4, emu_dt=7 -> enters HI, err_overshoot=1 and stays 1 until reset.
REQ-036 SHALL cover zero inputs: t_hi=0 -> dt_req=1 in HI; and emu_dt=0 for 20 cycles -> state and dt_req unchanged.
REQ-037 SHALL cover async reset: emu_rst_n low for half a cycle mid-HI -> all outputs reset immediately and dt_req all-ones; clean restart after release.
REQ-038 SHALL cover counter wrap: CNT_WIDTH=4, 17 rising edges -> edge_cnt=1.
